// File: rtl/offset_ext_pkg.sv
// Shared types for the offset extension arbiter.
// Mode, output-stage state and source encodings.
package offset_ext_pkg;

    typedef enum logic [1:0] {
        MODE_SEXT8 = 2'b00,
        MODE_ZEXT8 = 2'b01,
        MODE_SEXT4 = 2'b10,
        MODE_PASS  = 2'b11
    } mode_e;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef enum logic {
        SRC_ID  = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

endpackage

// File: rtl/offset_ext_arbiter_if.sv
// Request/result bundle between two requesters,
// the arbiter and the result consumer.
interface offset_ext_arbiter_if #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_offset;
    logic [1:0]        req0_mode;
    logic [TAG_W-1:0]  req0_tag;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_offset;
    logic [1:0]        req1_mode;
    logic [TAG_W-1:0]  req1_tag;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_src;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  req0_valid, req0_offset, req0_mode, req0_tag,
        input  req1_valid, req1_offset, req1_mode, req1_tag,
        input  out_ready,
        output req0_ready, req1_ready,
        output out_valid, out_data, out_src, out_tag
    );

    modport master (
        output req0_valid, req0_offset, req0_mode, req0_tag,
        output req1_valid, req1_offset, req1_mode, req1_tag,
        output out_ready,
        input  req0_ready, req1_ready,
        input  out_valid, out_data, out_src, out_tag
    );
endinterface

// File: rtl/offset_ext_unit.sv
// Combinational offset extender shared by both
// requesters; DATA_W must exceed 8.
import offset_ext_pkg::*;

module offset_ext_unit #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] offset_i,
    input  logic [1:0]        mode_i,
    output logic [DATA_W-1:0] ext_o
);

    // select the extension by mode
    always_comb begin
        ext_o = offset_i;
        unique case (mode_e'(mode_i))
            MODE_SEXT8:
                ext_o = {{(DATA_W-8){offset_i[7]}}, offset_i[7:0]};
            MODE_ZEXT8:
                ext_o = {{(DATA_W-8){1'b0}}, offset_i[7:0]};
            MODE_SEXT4:
                ext_o = {{(DATA_W-4){offset_i[3]}}, offset_i[3:0]};
            MODE_PASS:
                ext_o = offset_i;
            default:
                ext_o = offset_i;
        endcase
    end

endmodule

// File: rtl/offset_ext_arbiter.sv
// Round-robin arbiter for two offset requesters
// feeding one extender and a one-entry output stage.
import offset_ext_pkg::*;

module offset_ext_arbiter #(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 3
) (
    input  logic clk,
    input  logic rst,
    offset_ext_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    src_e              src_q, src_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    src_e              last_q, last_d;

    logic              drain;
    logic              can_load;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic [DATA_W-1:0] sel_offset;
    logic [1:0]        sel_mode;
    logic [DATA_W-1:0] ext;

    assign drain    = (state_q == ST_FULL) && bus.out_ready;
    assign can_load = !rst && ((state_q == ST_EMPTY) || drain);

    // grant one requester; ties go to the one not served last
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (can_load) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt0 = (last_q == SRC_MEM);
                gnt1 = (last_q == SRC_ID);
            end else begin
                gnt0 = bus.req0_valid;
                gnt1 = bus.req1_valid;
            end
        end
    end

    assign accept     = gnt0 | gnt1;
    assign sel_offset = gnt1 ? bus.req1_offset : bus.req0_offset;
    assign sel_mode   = gnt1 ? bus.req1_mode : bus.req0_mode;

    offset_ext_unit #(.DATA_W(DATA_W)) u_ext (
        .offset_i (sel_offset),
        .mode_i   (sel_mode),
        .ext_o    (ext)
    );

    // output stage next state: load on accept, clear on bare drain
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        src_d   = src_q;
        tag_d   = tag_q;
        last_d  = last_q;
        if (accept) begin
            state_d = ST_FULL;
            data_d  = ext;
            src_d   = gnt1 ? SRC_MEM : SRC_ID;
            tag_d   = gnt1 ? bus.req1_tag : bus.req0_tag;
            last_d  = gnt1 ? SRC_MEM : SRC_ID;
        end else if (drain) begin
            state_d = ST_EMPTY;
            data_d  = '0;
            src_d   = SRC_ID;
            tag_d   = '0;
        end
    end

    // state registers; reset drops any held result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            src_q   <= SRC_ID;
            tag_q   <= '0;
            last_q  <= SRC_MEM;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            src_q   <= src_d;
            tag_q   <= tag_d;
            last_q  <= last_d;
        end
    end

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.out_valid  = (state_q == ST_FULL);
    assign bus.out_data   = data_q;
    assign bus.out_src    = src_q;
    assign bus.out_tag    = tag_q;

endmodule

// File: tb/tb_offset_ext_arbiter.sv
// Self-checking bench for offset_ext_arbiter:
// vector table, corner sequences, random vs model.
module tb_offset_ext_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    offset_ext_arbiter_if #(.DATA_W(16), .TAG_W(3)) bus ();

    offset_ext_arbiter #(.DATA_W(16), .TAG_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        v0;
        logic        v1;
        logic [15:0] off0;
        logic [15:0] off1;
        logic [1:0]  mode0;
        logic [1:0]  mode1;
        logic [2:0]  tag0;
        logic [2:0]  tag1;
        logic        ordy;
    } stim_t;

    typedef struct {
        logic [15:0] off;
        logic [1:0]  mode;
        logic        src;
        logic [2:0]  tag;
        logic [15:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_full;
    logic [15:0] m_data;
    bit          m_src;
    logic [2:0]  m_tag;
    int          m_last;

    logic        rd0_s;
    logic        rd1_s;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_ext(logic [15:0] off,
                                          logic [1:0] mode);
        int v;
        int o;
        o = int'(off);
        case (mode)
            2'd0: begin
                v = o % 256;
                if (v >= 128) v = v - 256;
            end
            2'd1: v = o % 256;
            2'd2: begin
                v = o % 16;
                if (v >= 8) v = v - 16;
            end
            default: v = o;
        endcase
        return 16'(v);
    endfunction

    function automatic stim_t idle(logic ordy);
        stim_t s;
        s.v0 = 0; s.v1 = 0;
        s.off0 = '0; s.off1 = '0;
        s.mode0 = '0; s.mode1 = '0;
        s.tag0 = '0; s.tag1 = '0;
        s.ordy = ordy;
        return s;
    endfunction

    task automatic drive(stim_t s);
        bus.req0_valid  = s.v0;
        bus.req1_valid  = s.v1;
        bus.req0_offset = s.off0;
        bus.req1_offset = s.off1;
        bus.req0_mode   = s.mode0;
        bus.req1_mode   = s.mode1;
        bus.req0_tag    = s.tag0;
        bus.req1_tag    = s.tag1;
        bus.out_ready   = s.ordy;
    endtask

    task automatic chk_out();
        chk("out_valid", int'(bus.out_valid), int'(m_full));
        chk("out_data", int'(bus.out_data), int'(m_data));
        chk("out_src", int'(bus.out_src), int'(m_src));
        chk("out_tag", int'(bus.out_tag), int'(m_tag));
    endtask

    // called at a negedge; one full clock of stimulus
    task automatic step(stim_t s);
        int g;
        bit can;
        drive(s);
        #1;
        can = !m_full || s.ordy;
        g = -1;
        if (s.v0 && s.v1) g = (m_last == 0) ? 1 : 0;
        else if (s.v0) g = 0;
        else if (s.v1) g = 1;
        if (!can) g = -1;
        rd0_s = bus.req0_ready;
        rd1_s = bus.req1_ready;
        chk("req0_ready", int'(rd0_s), int'(g == 0));
        chk("req1_ready", int'(rd1_s), int'(g == 1));
        @(posedge clk);
        if (g >= 0) begin
            m_full = 1;
            m_data = (g == 1) ? m_ext(s.off1, s.mode1)
                              : m_ext(s.off0, s.mode0);
            m_src  = (g == 1);
            m_tag  = (g == 1) ? s.tag1 : s.tag0;
            m_last = g;
        end else if (m_full && s.ordy) begin
            m_full = 0;
            m_data = '0;
            m_src  = 0;
            m_tag  = '0;
        end
        @(negedge clk);
        chk_out();
    endtask

    task automatic do_reset(stim_t s);
        rst = 1'b1;
        drive(s);
        #1;
        chk("rst_ready0", int'(bus.req0_ready), 0);
        chk("rst_ready1", int'(bus.req1_ready), 0);
        @(posedge clk);
        m_full = 0;
        m_data = '0;
        m_src  = 0;
        m_tag  = '0;
        m_last = 1;
        @(negedge clk);
        rst = 1'b0;
        chk_out();
    endtask

    vec_t  tbl[8];
    stim_t s;
    stim_t both;
    logic [15:0] hold_d;
    logic        hold_s;
    logic [2:0]  hold_t;

    initial begin
        tbl[0] = '{16'h00FF, 2'b00, 1'b0, 3'd1, 16'hFFFF};
        tbl[1] = '{16'h0032, 2'b00, 1'b1, 3'd5, 16'h0032};
        tbl[2] = '{16'hAB08, 2'b10, 1'b1, 3'd2, 16'hFFF8};
        tbl[3] = '{16'h1280, 2'b01, 1'b0, 3'd3, 16'h0080};
        tbl[4] = '{16'h1234, 2'b11, 1'b1, 3'd7, 16'h1234};
        tbl[5] = '{16'hFF7F, 2'b00, 1'b0, 3'd4, 16'h007F};
        tbl[6] = '{16'h00F7, 2'b10, 1'b1, 3'd6, 16'h0007};
        tbl[7] = '{16'hABCD, 2'b01, 1'b0, 3'd0, 16'h00CD};

        drive(idle(1'b0));
        @(negedge clk);
        s = idle(1'b1);
        s.v0 = 1; s.v1 = 1;
        do_reset(s);

        // extension table, one requester at a time
        for (int i = 0; i < 8; i++) begin
            s = idle(1'b1);
            if (tbl[i].src) begin
                s.v1 = 1; s.off1 = tbl[i].off;
                s.mode1 = tbl[i].mode; s.tag1 = tbl[i].tag;
            end else begin
                s.v0 = 1; s.off0 = tbl[i].off;
                s.mode0 = tbl[i].mode; s.tag0 = tbl[i].tag;
            end
            step(s);
            chk("tbl_valid", int'(bus.out_valid), 1);
            chk("tbl_data", int'(bus.out_data), int'(tbl[i].exp));
            chk("tbl_src", int'(bus.out_src), int'(tbl[i].src));
            chk("tbl_tag", int'(bus.out_tag), int'(tbl[i].tag));
            step(idle(1'b1));
            chk("tbl_drain_data", int'(bus.out_data), 0);
        end

        // tie right after reset: req0 then req1
        do_reset(idle(1'b0));
        both = idle(1'b1);
        both.v0 = 1; both.v1 = 1;
        both.off0 = 16'h0011; both.off1 = 16'h0022;
        both.mode0 = 2'b11; both.mode1 = 2'b11;
        both.tag0 = 3'd1; both.tag1 = 3'd2;
        step(both);
        chk("tie_first_r0", int'(rd0_s), 1);
        chk("tie_first_src", int'(bus.out_src), 0);
        s = both; s.v0 = 0;
        step(s);
        chk("tie_second_r1", int'(rd1_s), 1);
        chk("tie_second_src", int'(bus.out_src), 1);
        step(idle(1'b1));

        // stall while full, then drain plus accept
        s = both; s.v1 = 0;
        step(s);
        hold_d = bus.out_data;
        hold_s = bus.out_src;
        hold_t = bus.out_tag;
        chk("stall_loaded", int'(hold_d), 16'h0011);
        s = both; s.ordy = 0;
        for (int i = 0; i < 3; i++) begin
            step(s);
            chk("stall_r0", int'(rd0_s), 0);
            chk("stall_r1", int'(rd1_s), 0);
            chk("stall_data", int'(bus.out_data), int'(hold_d));
            chk("stall_src", int'(bus.out_src), int'(hold_s));
            chk("stall_tag", int'(bus.out_tag), int'(hold_t));
        end
        step(both);
        chk("release_r1", int'(rd1_s), 1);
        chk("release_data", int'(bus.out_data), 16'h0022);

        // reset while full discards result
        chk("pre_rst_full", int'(bus.out_valid), 1);
        do_reset(both);
        chk("post_rst_valid", int'(bus.out_valid), 0);
        chk("post_rst_data", int'(bus.out_data), 0);
        step(both);
        chk("post_rst_tie_r0", int'(rd0_s), 1);
        step(idle(1'b1));

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            s.v0    = 1'($urandom_range(0, 1));
            s.v1    = 1'($urandom_range(0, 1));
            s.off0  = 16'($urandom);
            s.off1  = 16'($urandom);
            s.mode0 = 2'($urandom_range(0, 3));
            s.mode1 = 2'($urandom_range(0, 3));
            s.tag0  = 3'($urandom_range(0, 7));
            s.tag1  = 3'($urandom_range(0, 7));
            s.ordy  = ($urandom_range(0, 3) != 0);
            if (i % 97 == 50) do_reset(s);
            else step(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
